nabp_line_buffer_controller: RTL and testbench
==============================================

Name: nabp_line_buffer_controller

Overview:
Ping-pong controller for the filtered projection line buffer.
- Treats a dual port RAM of depth 2*pRAMSize as two banks; the address MSB selects the bank.
- Port 0 is driven write-only by the filtered-data stream. Port 1 is driven read-only by the back-projection datapath.
- Lets filtering of line n+1 overlap back-projection of line n, and sequences bank ownership between the two sides.

Parameters:
pDataLength, `kFilteredDataLength, width of one filtered sample
pRAMSize, `kProjectionLineSize, samples per projection line (= words per bank; need not be a power of 2)
pAddrLength, `kSLength, bits for an in-bank address, >= log2(pRAMSize)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
wr_valid  in  1  filtered sample present
wr_data  in  pDataLength  filtered sample
wr_ready  out  1  sample accepted when wr_valid && wr_ready
rd_bank_valid  out  1  a full line is available to the reader
rd_en  in  1  read request
rd_addr  in  pAddrLength  in-bank sample index, 0..pRAMSize-1
rd_data  out  pDataLength  read data
rd_data_valid  out  1  rd_data corresponds to the request of the previous cycle
rd_done  in  1  reader releases the current bank
ram_we_0  out  1  RAM port 0 write enable
ram_addr_0  out  pAddrLength+1  {wr_bank, wr_ptr}
ram_data_in_0  out  pDataLength  = wr_data
ram_we_1  out  1  constant 0
ram_addr_1  out  pAddrLength+1  {rd_bank, rd_addr}
ram_data_out_1  in  pDataLength  RAM port 1 registered output
wr_bank_o  out  1  bank currently being filled (status)
rd_bank_o  out  1  bank currently being read (status)

Behaviour:
- State registers:
  - wr_bank, rd_bank: 1 bit each.
  - full[1:0]: per-bank full flags.
  - wr_ptr: pAddrLength bits.
  - rd_pend: 1 bit.
- Reset: all state registers = 0. Outputs after reset: wr_ready=1, rd_bank_valid=0, rd_data_valid=0, ram_we_0=0.
- wr_ready = !full[wr_bank]. ram_we_0 = wr_valid && wr_ready. These are combinational, with no stalls beyond the full check.
- On each accepted write:
  - If wr_ptr != pRAMSize-1: wr_ptr increments.
  - If wr_ptr == pRAMSize-1: wr_ptr goes to 0, full[wr_bank] is set, and wr_bank toggles, all in the same edge.
- rd_bank_valid = full[rd_bank].
- Read accepted = rd_en && rd_bank_valid. rd_en while !rd_bank_valid is ignored and produces no rd_data_valid.
- Read latency is 1 cycle:
  - rd_pend <= read accepted.
  - rd_data_valid = rd_pend.
  - rd_data = ram_data_out_1, passed through.
- rd_addr >= pRAMSize is undefined; the bench must not drive it.
- rd_done while rd_bank_valid: full[rd_bank] is cleared and rd_bank toggles. rd_done while !rd_bank_valid is ignored.
- Simultaneous events:
  - rd_en and rd_done in the same cycle: the read is served from the old bank and its data is valid next cycle; the swap occurs on the same edge.
  - Write completion and rd_done in the same cycle always touch different banks (the writer only writes non-full banks, the reader only reads full banks). Both updates take effect.
  - Both banks full: wr_ready=0 until rd_done.
- Ordering: lines are read strictly in fill order, because both pointers toggle in the same sequence 0,1,0,...
- Reset mid-line: the partial line is discarded, flags and pointers return to 0, and a pending rd_data_valid is cleared next cycle. RAM contents are not cleared.

Decomposition:
- Shared defines header: `kFilteredDataLength, `kProjectionLineSize, `kSLength.
- No typedefs are needed.
- No sub-module: this is a single flat module. The parent instantiates the RAM with pRAMSize*2 depth and pAddrLength+1 address bits.

Test Plan:
All scenarios use pRAMSize=4 and pDataLength=8.
- Reset: hold reset 2 cycles with wr_valid=1 -> wr_ready=1, rd_bank_valid=0, ram_we_0=0 throughout, rd_data_valid=0.
- Single fill/read:
  - Stimulus: stream 0x10..0x13, then read addresses 3,0.
  - Writes go to ram_addr_0=0..3. rd_bank_valid rises the cycle after the 4th write.
  - Reads give rd_data 0x13 then 0x10, each one cycle after its request, with rd_data_valid=1.
- Overlap and backpressure:
  - Stimulus: fill bank 0 (0x10..0x13), then bank 1 (0x20..0x23), then offer 0x30.
  - ram_addr_0 runs 4..7 for bank 1. wr_ready=0 and 0x30 stalls.
  - Pulse rd_done: wr_ready rises the next cycle, 0x30 is written to address 0, and rd_bank_o=1. Reading addr 2 then returns 0x22.
- Simultaneous rd_en+rd_done with bank 1 also full:
  - Stimulus: rd_en at addr 1 with rd_done in the same cycle.
  - Next cycle returns the bank-0 word 0x11 with valid. ram_addr_1 MSB is 1 afterwards.
- Illegal requests with no full bank:
  - Stimulus: rd_en and rd_done pulses.
  - rd_data_valid stays 0, and rd_bank_o and the full flags are unchanged.
- Reset mid-operation:
  - Stimulus: after 2 of 4 writes and with a read in flight, assert reset.
  - rd_data_valid=0 next cycle. A subsequent 4-word fill starts at address 0.

Source files
------------

// File: rtl/nabp_line_buffer_controller_pkg.sv
// Shared sizing constants for the filtered projection line buffer.
package nabp_line_buffer_controller_pkg;

  localparam int kFilteredDataLength = 16;
  localparam int kProjectionLineSize = 256;
  localparam int kSLength            = 8;

endpackage

// File: rtl/nabp_line_buffer_controller.sv
// Ping-pong bank controller: the filter fills one RAM bank while the
// back-projector reads the other, with banks handed over in fill order.
module nabp_line_buffer_controller
  import nabp_line_buffer_controller_pkg::*;
#(
  parameter int pDataLength = kFilteredDataLength,
  parameter int pRAMSize    = kProjectionLineSize,
  parameter int pAddrLength = kSLength
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [pDataLength-1:0] wr_data,
  output logic                   wr_ready,
  output logic                   rd_bank_valid,
  input  logic                   rd_en,
  input  logic [pAddrLength-1:0] rd_addr,
  output logic [pDataLength-1:0] rd_data,
  output logic                   rd_data_valid,
  input  logic                   rd_done,
  output logic                   ram_we_0,
  output logic [pAddrLength:0]   ram_addr_0,
  output logic [pDataLength-1:0] ram_data_in_0,
  output logic                   ram_we_1,
  output logic [pAddrLength:0]   ram_addr_1,
  input  logic [pDataLength-1:0] ram_data_out_1,
  output logic                   wr_bank_o,
  output logic                   rd_bank_o
);

  localparam logic [pAddrLength-1:0] LastAddr = pAddrLength'(pRAMSize - 1);

  logic                   wrBank_q, wrBank_d;
  logic                   rdBank_q, rdBank_d;
  logic [1:0]             full_q, full_d;
  logic [pAddrLength-1:0] wrPtr_q, wrPtr_d;
  logic                   rdPend_q, rdPend_d;

  logic wrAccept;
  logic rdAccept;
  logic bankRelease;

  assign wr_ready      = !full_q[wrBank_q];
  assign rd_bank_valid = full_q[rdBank_q];

  // Reset blocks the RAM write so a sample offered during reset never lands.
  assign wrAccept    = wr_valid && wr_ready && !reset;
  assign rdAccept    = rd_en && rd_bank_valid;
  assign bankRelease = rd_done && rd_bank_valid;

  assign ram_we_0      = wrAccept;
  assign ram_addr_0    = {wrBank_q, wrPtr_q};
  assign ram_data_in_0 = wr_data;
  assign ram_we_1      = 1'b0;
  assign ram_addr_1    = {rdBank_q, rd_addr};
  assign rd_data       = ram_data_out_1;
  assign rd_data_valid = rdPend_q;
  assign wr_bank_o     = wrBank_q;
  assign rd_bank_o     = rdBank_q;

  always_comb begin
    wrBank_d = wrBank_q;
    rdBank_d = rdBank_q;
    full_d   = full_q;
    wrPtr_d  = wrPtr_q;
    rdPend_d = rdAccept;
    if (wrAccept) begin
      if (wrPtr_q == LastAddr) begin
        wrPtr_d          = '0;
        full_d[wrBank_q] = 1'b1;
        wrBank_d         = !wrBank_q;
      end else begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
    end
    // The writer only touches non-full banks, so this never collides with the fill above.
    if (bankRelease) begin
      full_d[rdBank_q] = 1'b0;
      rdBank_d         = !rdBank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrBank_q <= 1'b0;
      rdBank_q <= 1'b0;
      full_q   <= 2'b00;
      wrPtr_q  <= '0;
      rdPend_q <= 1'b0;
    end else begin
      wrBank_q <= wrBank_d;
      rdBank_q <= rdBank_d;
      full_q   <= full_d;
      wrPtr_q  <= wrPtr_d;
      rdPend_q <= rdPend_d;
    end
  end

endmodule

// File: tb/tb_nabp_line_buffer_controller.sv
// Directed bench for the ping-pong line buffer controller, with a
// behavioural dual-port RAM (registered port-1 output) attached.
module tb_nabp_line_buffer_controller;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wrValid;
  logic [DW-1:0] wrData;
  logic          wrReady;
  logic          rdBankValid;
  logic          rdEn;
  logic [AW-1:0] rdAddr;
  logic [DW-1:0] rdData;
  logic          rdDataValid;
  logic          rdDone;
  logic          ramWe0;
  logic [AW:0]   ramAddr0;
  logic [DW-1:0] ramDataIn0;
  logic          ramWe1;
  logic [AW:0]   ramAddr1;
  logic [DW-1:0] ramDataOut1;
  logic          wrBank;
  logic          rdBank;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [DW-1:0] mem [0:7];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWe0) mem[ramAddr0] <= ramDataIn0;
    ramDataOut1 <= mem[ramAddr1];
  end

  nabp_line_buffer_controller #(
    .pDataLength(DW),
    .pRAMSize   (4),
    .pAddrLength(AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wrValid),
    .wr_data       (wrData),
    .wr_ready      (wrReady),
    .rd_bank_valid (rdBankValid),
    .rd_en         (rdEn),
    .rd_addr       (rdAddr),
    .rd_data       (rdData),
    .rd_data_valid (rdDataValid),
    .rd_done       (rdDone),
    .ram_we_0      (ramWe0),
    .ram_addr_0    (ramAddr0),
    .ram_data_in_0 (ramDataIn0),
    .ram_we_1      (ramWe1),
    .ram_addr_1    (ramAddr1),
    .ram_data_out_1(ramDataOut1),
    .wr_bank_o     (wrBank),
    .rd_bank_o     (rdBank)
  );

  // Advance one clock; inputs are then driven 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wrValid = 1'b0;
    wrData  = '0;
    rdEn    = 1'b0;
    rdAddr  = '0;
    rdDone  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic fillLine(input logic [DW-1:0] base);
    for (int i = 0; i < 4; i++) begin
      wrValid = 1'b1;
      wrData  = base + DW'(i);
      tick();
    end
    wrValid = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    idleInputs();
    wrValid = 1'b1;
    wrData  = 8'h55;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      testsRun++;
      if (wrReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_wr_ready cyc%0d: got %b want 1", c, wrReady); end
      testsRun++;
      if (rdBankValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_bank_valid cyc%0d: got %b want 0", c, rdBankValid); end
      testsRun++;
      if (ramWe0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ram_we_0 cyc%0d: got %b want 0", c, ramWe0); end
      testsRun++;
      if (rdDataValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_data_valid cyc%0d: got %b want 0", c, rdDataValid); end
    end
    tick();
    reset   = 1'b0;
    wrValid = 1'b0;
    #1;
    testsRun++;
    if (ramWe1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL ram_we_1: got %b want 0", ramWe1); end
  endtask

  task automatic test_single_fill_read();
    doReset();
    for (int i = 0; i < 4; i++) begin
      wrValid = 1'b1;
      wrData  = 8'h10 + DW'(i);
      #1;
      testsRun++;
      if (ramWe0 !== 1'b1 || ramAddr0 !== 3'(i) || ramDataIn0 !== 8'h10 + DW'(i)) begin
        testsFailed++;
        $display("[TB] FAIL fill_write%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 i, ramWe0, ramAddr0, ramDataIn0, i, 8'h10 + DW'(i));
      end
      testsRun++;
      if (rdBankValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_early_valid%0d: got %b want 0", i, rdBankValid); end
      tick();
    end
    wrValid = 1'b0;
    #1;
    testsRun++;
    if (rdBankValid !== 1'b1 || wrBank !== 1'b1 || wrReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL fill_complete: got valid=%b wr_bank=%b wr_ready=%b want 1 1 1", rdBankValid, wrBank, wrReady);
    end
    rdEn   = 1'b1;
    rdAddr = 2'd3;
    #1;
    testsRun++;
    if (ramAddr1 !== 3'd3) begin testsFailed++; $display("[TB] FAIL read_addr: got %0d want 3", ramAddr1); end
    tick();
    rdAddr = 2'd0;
    #1;
    testsRun++;
    if (rdDataValid !== 1'b1 || rdData !== 8'h13) begin
      testsFailed++;
      $display("[TB] FAIL read_addr3: got valid=%b data=%h want 1 13", rdDataValid, rdData);
    end
    tick();
    rdEn = 1'b0;
    #1;
    testsRun++;
    if (rdDataValid !== 1'b1 || rdData !== 8'h10) begin
      testsFailed++;
      $display("[TB] FAIL read_addr0: got valid=%b data=%h want 1 10", rdDataValid, rdData);
    end
    tick();
    testsRun++;
    if (rdDataValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_idle_valid: got %b want 0", rdDataValid); end
  endtask

  task automatic test_overlap_backpressure();
    doReset();
    fillLine(8'h10);
    for (int i = 0; i < 4; i++) begin
      wrValid = 1'b1;
      wrData  = 8'h20 + DW'(i);
      #1;
      testsRun++;
      if (ramWe0 !== 1'b1 || ramAddr0 !== 3'(4 + i)) begin
        testsFailed++;
        $display("[TB] FAIL bank1_write%0d: got we=%b addr=%0d want we=1 addr=%0d", i, ramWe0, ramAddr0, 4 + i);
      end
      tick();
    end
    wrData = 8'h30;
    #1;
    testsRun++;
    if (wrReady !== 1'b0 || ramWe0 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL both_full_stall: got wr_ready=%b we=%b want 0 0", wrReady, ramWe0);
    end
    tick();
    rdDone = 1'b1;
    #1;
    testsRun++;
    if (wrReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_during_done: got %b want 0", wrReady); end
    tick();
    rdDone = 1'b0;
    #1;
    testsRun++;
    if (wrReady !== 1'b1 || ramWe0 !== 1'b1 || ramAddr0 !== 3'd0 || rdBank !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL release_resume: got wr_ready=%b we=%b addr=%0d rd_bank=%b want 1 1 0 1",
               wrReady, ramWe0, ramAddr0, rdBank);
    end
    tick();
    wrValid = 1'b0;
    rdEn    = 1'b1;
    rdAddr  = 2'd2;
    #1;
    testsRun++;
    if (ramAddr1 !== 3'd6) begin testsFailed++; $display("[TB] FAIL bank1_read_addr: got %0d want 6", ramAddr1); end
    tick();
    rdEn = 1'b0;
    #1;
    testsRun++;
    if (rdDataValid !== 1'b1 || rdData !== 8'h22) begin
      testsFailed++;
      $display("[TB] FAIL bank1_read: got valid=%b data=%h want 1 22", rdDataValid, rdData);
    end
  endtask

  task automatic test_read_and_done();
    doReset();
    fillLine(8'h10);
    fillLine(8'h20);
    rdEn   = 1'b1;
    rdAddr = 2'd1;
    rdDone = 1'b1;
    #1;
    testsRun++;
    if (ramAddr1 !== 3'd1) begin testsFailed++; $display("[TB] FAIL same_cycle_addr: got %0d want 1", ramAddr1); end
    tick();
    rdEn   = 1'b0;
    rdDone = 1'b0;
    rdAddr = 2'd0;
    #1;
    testsRun++;
    if (rdDataValid !== 1'b1 || rdData !== 8'h11) begin
      testsFailed++;
      $display("[TB] FAIL same_cycle_data: got valid=%b data=%h want 1 11", rdDataValid, rdData);
    end
    testsRun++;
    if (ramAddr1[AW] !== 1'b1 || rdBank !== 1'b1 || rdBankValid !== 1'b1 || wrReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL same_cycle_swap: got msb=%b rd_bank=%b valid=%b wr_ready=%b want 1 1 1 1",
               ramAddr1[AW], rdBank, rdBankValid, wrReady);
    end
  endtask

  task automatic test_illegal_requests();
    doReset();
    rdEn   = 1'b1;
    rdAddr = 2'd2;
    rdDone = 1'b1;
    tick();
    rdEn   = 1'b0;
    rdDone = 1'b0;
    #1;
    testsRun++;
    if (rdDataValid !== 1'b0 || rdBank !== 1'b0 || rdBankValid !== 1'b0 || wrReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL illegal_ignored: got valid=%b rd_bank=%b bank_valid=%b wr_ready=%b want 0 0 0 1",
               rdDataValid, rdBank, rdBankValid, wrReady);
    end
    fillLine(8'h50);
    #1;
    testsRun++;
    if (rdBankValid !== 1'b1 || rdBank !== 1'b0 || wrBank !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL illegal_then_fill: got valid=%b rd_bank=%b wr_bank=%b want 1 0 1", rdBankValid, rdBank, wrBank);
    end
  endtask

  task automatic test_reset_mid_operation();
    doReset();
    fillLine(8'h10);
    wrValid = 1'b1;
    wrData  = 8'h40;
    tick();
    wrData = 8'h41;
    rdEn   = 1'b1;
    rdAddr = 2'd0;
    tick();
    reset = 1'b1;
    idleInputs();
    #1;
    testsRun++;
    if (rdDataValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL inflight_before_reset: got %b want 1", rdDataValid); end
    tick();
    testsRun++;
    if (rdDataValid !== 1'b0 || rdBankValid !== 1'b0 || wrBank !== 1'b0 || rdBank !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_state: got valid=%b bank_valid=%b wr_bank=%b rd_bank=%b want 0 0 0 0",
               rdDataValid, rdBankValid, wrBank, rdBank);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wrValid = 1'b1;
      wrData  = 8'h60 + DW'(i);
      #1;
      testsRun++;
      if (ramWe0 !== 1'b1 || ramAddr0 !== 3'(i)) begin
        testsFailed++;
        $display("[TB] FAIL refill_write%0d: got we=%b addr=%0d want we=1 addr=%0d", i, ramWe0, ramAddr0, i);
      end
      tick();
    end
    wrValid = 1'b0;
    #1;
    testsRun++;
    if (rdBankValid !== 1'b1 || rdBank !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL refill_done: got valid=%b rd_bank=%b want 1 0", rdBankValid, rdBank);
    end
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    test_reset();
    test_single_fill_read();
    test_overlap_backpressure();
    test_read_and_done();
    test_illegal_requests();
    test_reset_mid_operation();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
